// File: rtl/instruction_loader_pkg.sv
// Shared types and defaults for the instruction loader and its RAM.
package instruction_loader_pkg;

    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_ADDR_W = 6;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instruction_loader_instr_ram.sv
// Instruction store: one synchronous write port, one combinational read port.
module instr_ram #(
    parameter int DEPTH  = instruction_loader_pkg::DEFAULT_DEPTH,
    parameter int ADDR_W = instruction_loader_pkg::DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Contents deliberately survive reset so a reloaded program only overwrites what it covers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_loader.sv
// Loads the instruction RAM from a little-endian byte stream and holds the
// processor in reset until a complete program is resident.
//
// state | meaning
// IDLE  | no program loaded, processor held in reset
// LOAD  | accepting bytes, processor held in reset
// DONE  | program resident, processor released
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    input  logic            load_end,
    input  logic [31:0]     A,
    output logic [31:0]     RD,
    output logic            cpu_reset,
    output logic            load_done,
    output logic            full,
    output logic [ADDR_W:0] word_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_ptr_q, word_ptr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         asm_q, asm_d;
    logic                full_q, full_d;

    logic                hs;
    logic [31:0]         asm_merged;
    logic [1:0]          idx_after;
    logic                word_done;
    logic                pad_write;
    logic                we;
    logic                last_write;
    logic                unused_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            word_ptr_q   <= '0;
            word_count_q <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_ptr_q   <= word_ptr_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        hs         = (state_q == LOAD) && byte_valid;
        asm_merged = asm_q;
        if (hs) begin
            asm_merged[{byte_idx_q, 3'b000} +: 8] = byte_data;
        end
        idx_after  = hs ? byte_idx_q + 2'd1 : byte_idx_q;
        word_done  = hs && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
        // A trailing partial word is flushed on load_end; upper lanes are already zero.
        pad_write  = (state_q == LOAD) && load_end && !word_done && (idx_after != 2'd0);
        we         = word_done || pad_write;
        last_write = we && (word_ptr_q == ADDR_W'(DEPTH - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (load_end || last_write) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_ptr_d   = word_ptr_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        full_d       = full_q;
        if ((state_q != LOAD) && load_start) begin
            word_ptr_d   = '0;
            word_count_d = '0;
            byte_idx_d   = '0;
            asm_d        = '0;
            full_d       = 1'b0;
        end else if (state_q == LOAD) begin
            byte_idx_d = idx_after;
            asm_d      = asm_merged;
            if (we) begin
                word_ptr_d   = word_ptr_q + ADDR_W'(1);
                word_count_d = word_count_q + (ADDR_W + 1)'(1);
                byte_idx_d   = '0;
                asm_d        = '0;
            end
            if (last_write) begin
                full_d = 1'b1;
            end
        end
    end

    always_comb begin
        cpu_reset  = (state_q != DONE);
        byte_ready = (state_q == LOAD);
        load_done  = (state_q == DONE);
    end

    assign full       = full_q;
    assign word_count = word_count_q;
    assign unused_a   = ^{A[31:ADDR_W+2], A[1:0]};

    instr_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (word_ptr_q),
        .wdata (asm_merged),
        .raddr (A[ADDR_W+1:2]),
        .rdata (RD)
    );

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader with a byte-queue reference model.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    localparam int DEPTH  = DEFAULT_DEPTH;
    localparam int ADDR_W = DEFAULT_ADDR_W;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_start;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            load_end;
    logic [31:0]     A;
    logic [31:0]     RD;
    logic            cpu_reset;
    logic            load_done;
    logic            full;
    logic [ADDR_W:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];
    logic [7:0]  q [$];
    bit          exp_loading;
    bit          exp_done;
    bit          exp_full;
    int          exp_count;

    instruction_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .load_end   (load_end),
        .A          (A),
        .RD         (RD),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .full       (full),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(int i);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            if (4 * i + b < q.size()) w[8*b +: 8] = q[4*i+b];
        end
        return w;
    endfunction

    function automatic void commit(int nwords);
        for (int i = 0; i < nwords; i++) begin
            model_mem[i] = word_of(i);
            known[i]     = 1'b1;
        end
    endfunction

    // One clock of stimulus; the model consumes the same cycle at stream level.
    task automatic drive_cycle(input bit v, input logic [7:0] d, input bit st, input bit en);
        @(negedge clk);
        byte_valid = v;
        byte_data  = d;
        load_start = st;
        load_end   = en;
        if (exp_loading) begin
            if (v) q.push_back(d);
            if (q.size() == 4 * DEPTH) begin
                commit(DEPTH);
                exp_count = DEPTH; exp_full = 1'b1; exp_loading = 1'b0; exp_done = 1'b1;
            end else if (en) begin
                exp_count = (q.size() + 3) / 4;
                commit(exp_count);
                exp_loading = 1'b0; exp_done = 1'b1;
            end else begin
                exp_count = q.size() / 4;
            end
        end else if (st) begin
            q.delete();
            exp_loading = 1'b1; exp_done = 1'b0; exp_full = 1'b0; exp_count = 0;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        load_start = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 0; byte_valid = 0; byte_data = 0; load_end = 0; A = 0;
        exp_loading = 0; exp_done = 0; exp_full = 0; exp_count = 0;
        #12;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b want 0", byte_ready); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b want 0", load_done); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_word_count got %0d want 0", word_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] bytes [8];
        bytes = '{8'h00, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2};
        drive_cycle(0, 0, 1, 0);
        checks++; if (byte_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_in_load ready=%b cpu_reset=%b want 1 1", byte_ready, cpu_reset); end
        foreach (bytes[i]) drive_cycle(1, bytes[i], 0, 0);
        drive_cycle(0, 0, 0, 1);
        checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL basic_done cpu_reset=%b load_done=%b want 0 1", cpu_reset, load_done); end
        checks++; if (word_count !== 7'd2) begin errors++; $display("FAIL basic_count got %0d want 2", word_count); end
        A = 32'h0; #1;
        checks++; if (RD !== 32'hE3A00000) begin errors++; $display("FAIL basic_rd0 got %h want e3a00000", RD); end
        A = 32'h4; #1;
        checks++; if (RD !== 32'hE2811001) begin errors++; $display("FAIL basic_rd4 got %h want e2811001", RD); end
        A = 32'h7; #1;
        checks++; if (RD !== 32'hE2811001) begin errors++; $display("FAIL basic_rd7 got %h want e2811001", RD); end
    endtask

    task automatic test_end_same_cycle();
        drive_cycle(0, 0, 1, 0);
        drive_cycle(1, 8'h11, 0, 0);
        drive_cycle(1, 8'h22, 0, 0);
        drive_cycle(1, 8'h33, 0, 0);
        drive_cycle(1, 8'h44, 0, 0);
        drive_cycle(1, 8'h55, 0, 1);
        checks++; if (load_done !== 1'b1 || word_count !== 7'd2) begin errors++; $display("FAIL pad_status done=%b count=%0d want 1 2", load_done, word_count); end
        A = 32'hFFFF_FF00; #1;
        checks++; if (RD !== 32'h44332211) begin errors++; $display("FAIL pad_rd0 got %h want 44332211", RD); end
        A = 32'h0000_0005; #1;
        checks++; if (RD !== 32'h00000055) begin errors++; $display("FAIL pad_rd1 got %h want 00000055", RD); end
    endtask

    task automatic test_full();
        drive_cycle(0, 0, 1, 0);
        for (int i = 0; i < 4 * DEPTH; i++) drive_cycle(1, 8'($urandom), 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", full); end
        checks++; if (word_count !== 7'(exp_count)) begin errors++; $display("FAIL full_count got %0d want %0d", word_count, exp_count); end
        checks++; if (byte_ready !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL full_state ready=%b done=%b want 0 1", byte_ready, load_done); end
        drive_cycle(1, 8'hEE, 0, 0);
        checks++; if (word_count !== 7'(exp_count)) begin errors++; $display("FAIL full_extra_count got %0d want %0d", word_count, exp_count); end
        for (int i = 0; i < DEPTH; i++) begin
            A = $urandom; A[ADDR_W+1:2] = ADDR_W'(i); #1;
            checks++; if (RD !== model_mem[i]) begin errors++; $display("FAIL full_mem[%0d] got %h want %h", i, RD, model_mem[i]); end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] bytes [4];
        logic [31:0] old1;
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        old1 = model_mem[1];
        drive_cycle(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) drive_cycle(i % 2 == 0, (i % 2 == 0) ? bytes[i/2] : 8'hFF, 0, 0);
        checks++; if (word_count !== 7'd1 || byte_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL toggle_mid count=%0d ready=%b full=%b want 1 1 0", word_count, byte_ready, full); end
        drive_cycle(0, 0, 0, 1);
        checks++; if (word_count !== 7'd1) begin errors++; $display("FAIL toggle_count got %0d want 1", word_count); end
        A = 32'h0; #1;
        checks++; if (RD !== 32'hD4C3B2A1) begin errors++; $display("FAIL toggle_rd0 got %h want d4c3b2a1", RD); end
        A = 32'h4; #1;
        checks++; if (RD !== old1) begin errors++; $display("FAIL toggle_rd1 got %h want %h", RD, old1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old1;
        old1 = model_mem[1];
        drive_cycle(0, 0, 1, 0);
        for (int i = 1; i <= 6; i++) drive_cycle(1, 8'(i), 0, 0);
        #2;
        reset = 1'b1;
        commit(q.size() / 4);
        exp_loading = 0; exp_done = 0; exp_full = 0; exp_count = 0;
        #1;
        checks++; if (cpu_reset !== 1'b1 || byte_ready !== 1'b0 || word_count !== '0) begin errors++; $display("FAIL rstmid_state cpu_reset=%b ready=%b count=%0d want 1 0 0", cpu_reset, byte_ready, word_count); end
        A = 32'h0; #1;
        checks++; if (RD !== 32'h04030201) begin errors++; $display("FAIL rstmid_rd0 got %h want 04030201", RD); end
        A = 32'h4; #1;
        checks++; if (RD !== old1) begin errors++; $display("FAIL rstmid_rd1 got %h want %h", RD, old1); end
        @(negedge clk);
        reset = 1'b0;
        drive_cycle(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive_cycle(1, 8'h90 + 8'(i), 0, 0);
        drive_cycle(0, 0, 0, 1);
        A = 32'h0; #1;
        checks++; if (RD !== 32'h93929190 || word_count !== 7'd1) begin errors++; $display("FAIL rstmid_reload rd0=%h count=%0d want 93929190 1", RD, word_count); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int  n;
            bit  ended;
            n = $urandom_range(1, 40);
            ended = 0;
            drive_cycle(0, 0, 1, 0);
            for (int k = 0; k < n; k++) begin
                while ($urandom_range(0, 2) == 0) drive_cycle(0, 8'($urandom), $urandom_range(0, 3) == 0, 0);
                ended = (k == n - 1) && ($urandom_range(0, 1) == 1);
                drive_cycle(1, 8'($urandom), 0, ended);
            end
            if (!ended) drive_cycle(0, 0, 0, 1);
            drive_cycle(0, 0, 0, 1);
            checks++; if (word_count !== 7'(exp_count) || load_done !== exp_done || full !== exp_full) begin
                errors++; $display("FAIL rand%0d_status count=%0d done=%b full=%b want %0d %b %b", it, word_count, load_done, full, exp_count, exp_done, exp_full);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (known[i]) begin
                    A = $urandom; A[ADDR_W+1:2] = ADDR_W'(i); #1;
                    checks++; if (RD !== model_mem[i]) begin errors++; $display("FAIL rand%0d_mem[%0d] got %h want %h", it, i, RD, model_mem[i]); end
                end
            end
        end
    endtask

    initial begin
        foreach (known[i]) known[i] = 1'b0;
        test_reset();
        test_basic();
        test_end_same_cycle();
        test_full();
        test_toggle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the processor's instruction store. Owns a DEPTH-word x 32-bit instruction RAM. The RAM is loaded from a handshaked byte stream (little-endian word assembly, sequential word addresses from 0). The processor fetch path reads it combinationally through a word-aligned A/RD port. The block holds the processor in reset until a load completes.

Parameters:
DEPTH, 64, number of 32-bit instruction words
ADDR_W, 6, word-address width, equal to log2(DEPTH)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
load_start  input  1  one-cycle pulse that begins a load
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
load_end  input  1  one-cycle pulse marking end of stream
A  input  32  fetch byte address
RD  output  32  instruction word at A
cpu_reset  output  1  holds the processor in reset
load_done  output  1  high while a completed program is resident
full  output  1  last load stopped because the memory filled
word_count  output  ADDR_W+1  words written by the current or last load

Behaviour:
- Async reset state: IDLE. cpu_reset=1, byte_ready=0, load_done=0, full=0, word_count=0, byte_idx=0, assembly register=0. RAM contents are not reset.
- States:
  - IDLE: cpu_reset=1, byte_ready=0.
  - LOAD: cpu_reset=1, byte_ready=1.
  - DONE: cpu_reset=0, load_done=1, byte_ready=0.
- byte_ready is a Moore output, high exactly while in LOAD. A handshake is byte_valid && byte_ready, sampled at the rising edge of clk.
- IDLE or DONE, load_start=1: next state LOAD. word_ptr=0, word_count=0, byte_idx=0, assembly register=0, full=0, load_done=0.
- load_start in LOAD is ignored. load_end in IDLE or DONE is ignored.
- LOAD, byte handshake: byte_data goes into lane byte_idx (byte 0 -> bits 7:0, byte 3 -> bits 31:24), then byte_idx increments.
  - When byte_idx was 3, on the same edge: mem[word_ptr] <= assembled word including the incoming byte; word_ptr++, word_count++, byte_idx=0, assembly register cleared.
- LOAD, load_end=1:
  - Processed after any same-cycle byte handshake.
  - If bytes of a partial word remain (byte_idx != 0 after the byte update), that word is written zero-padded in the upper lanes, and word_count increments.
  - Next state DONE.
- Memory full: a write to word DEPTH-1 sets full=1, and the next state is DONE whether or not load_end is asserted. No further bytes are accepted.
- Read port: RD = mem[A[ADDR_W+1:2]], combinational. A[1:0] and A[31:ADDR_W+2] are ignored.
- A read of the same word being written returns the old data until the edge; the new data appears after the edge.
- Reset mid-load: returns to IDLE with the reset values. Words already written remain in the RAM.
- Write latency: 0 cycles after the handshake edge; RD reflects the new word in the next cycle.

Decomposition:
- Shared package (e.g. loader_pkg): state enum {IDLE, LOAD, DONE}, DEPTH/ADDR_W defaults, byte-lane constant BYTES_PER_WORD=4.
- One natural sub-module, instr_ram: DEPTH x 32, one synchronous write port, one combinational read port.
- The FSM, byte assembly and counters stay in instruction_loader.

Test Plan:
- Power-on reset -> cpu_reset=1, byte_ready=0, load_done=0, full=0, word_count=0.
- load_start, then bytes 00 00 A0 E3 01 10 81 E2, then load_end pulse:
  - mem[0]=32'hE3A00000, mem[1]=32'hE2811001, word_count=2.
  - Next cycle: state DONE, cpu_reset=0.
  - A=32'h4 -> RD=32'hE2811001; A=32'h7 -> also E2811001.
- Bytes 11 22 33 44 55, with load_end asserted in the same cycle as the 55 handshake:
  - mem[0]=32'h44332211, mem[1]=32'h00000055, word_count=2, DONE.
- 256 bytes with byte_valid continuously high:
  - After the 256th handshake: full=1, word_count=64, byte_ready=0 the next cycle.
  - A 257th byte stays pending and is not written.
- byte_valid toggled every other cycle for 4 bytes -> exactly one word written, word_count=1, no duplicated or dropped bytes.
- Reset asserted asynchronously after 6 bytes:
  - Immediately: cpu_reset=1, byte_ready=0, word_count=0.
  - mem[0] retains its word; mem[1] is unchanged.
  - A fresh load then restarts at word 0.
